// File: rtl/sm2tc_serial.sv
// rtl/sm2tc_serial.sv - bit-serial sign-magnitude to two's-complement converter
// LSB-first negation: copy bits through the first 1, invert the remainder.
module sm2tc_serial #(
  parameter int WIDTH = 12,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             S,
  input  logic [WIDTH-2:0] M,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             nz
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 2);

  state_t           state_q, state_d;
  logic             s_q, s_d;
  logic             seen_q, seen_d;
  logic [WIDTH-2:0] m_q, m_d;
  logic [WIDTH-2:0] r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             nz_q, nz_d;
  logic             b, o;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    seen_d  = seen_q;
    m_d     = m_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    nz_d    = nz_q;
    b       = m_q[0];
    o       = (s_q & seen_q) ? ~b : b;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d     = S;
          m_d     = M;
          r_d     = '0;
          cnt_d   = '0;
          seen_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        seen_d = seen_q | b;
        m_d    = m_q >> 1;
        r_d    = {o, r_q[WIDTH-2:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Sign bit only when a 1 was seen, so negative zero becomes +0.
          d_d     = {s_q & seen_d, r_d};
          nz_d    = s_q & ~seen_d;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= 1'b0;
      seen_q  <= 1'b0;
      m_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      d_q     <= '0;
      nz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      seen_q  <= seen_d;
      m_q     <= m_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      nz_q    <= nz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign D         = d_q;
  assign nz        = nz_q;

endmodule

// File: tb/tb_sm2tc_serial.sv
// tb/tb_sm2tc_serial.sv - directed and streaming scoreboard bench for sm2tc_serial
module tb_sm2tc_serial;

  localparam int W = 12;

  typedef struct {
    logic [W-1:0] d;
    logic         nz;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         S;
  logic [W-2:0] M;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] D;
  logic         nz;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic ov_seen = 1'b0;

  sm2tc_serial #(.WIDTH(W), .CW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .S(S), .M(M), .out_valid(out_valid), .out_ready(out_ready),
    .D(D), .nz(nz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic s, input logic [W-2:0] m, input int acc);
    exp_t e;
    logic [W-1:0] mag;
    mag   = {1'b0, m};
    e.d   = (s && m != 0) ? (~mag + 1'b1) : mag;
    e.nz  = s && (m == 0);
    e.acc = acc;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic send(input logic s, input logic [W-2:0] m, input logic hold, output int acc);
    in_valid = 1'b1;
    S = s;
    M = m;
    for (int n = 0; n < 50 && !in_ready; n++) @(negedge clk);
    check("send_in_ready", in_ready, 1'b1);
    acc = cyc + 1;
    sb.push_back(model(s, m, acc));
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
    S = $urandom_range(0, 1);
    M = W'($urandom_range(0, 2047));
  endtask

  task automatic run_word(input logic s, input logic [W-2:0] m);
    int acc;
    send(s, m, 1'b0, acc);
    @(negedge clk);
    for (int n = 0; n < 50 && !in_ready; n++) @(negedge clk);
    check("word_back_idle", in_ready, 1'b1);
  endtask

  always @(negedge clk) begin
    if (out_valid && !ov_seen) begin
      exp_t e;
      ov_seen = 1'b1;
      check("output_expected", sb.size() > 0, 1'b1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("D", D, e.d);
        check("nz", nz, e.nz);
        check("latency", cyc, e.acc + 11);
      end
    end else if (!out_valid) begin
      ov_seen = 1'b0;
    end
  end

  initial begin
    int acc, prev_acc;
    rst = 1'b1; in_valid = 1'b0; S = 1'b0; M = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_D", D, 12'h000);
    check("rst_nz", nz, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);

    out_ready = 1'b1;
    send(1'b0, 11'h3A5, 1'b0, acc);
    for (int k = 0; k < 12; k++) begin
      check("busy_in_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    check("idle_after_transfer", in_ready, 1'b1);

    run_word(1'b1, 11'h001);
    run_word(1'b1, 11'h7FF);
    run_word(1'b1, 11'h000);
    run_word(1'b0, 11'h000);

    // Backpressure: result held while a new word waits upstream.
    out_ready = 1'b0;
    send(1'b1, 11'h400, 1'b0, acc);
    for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
    check("bp_out_valid", out_valid, 1'b1);
    in_valid = 1'b1; S = 1'b1; M = 11'h123;
    repeat (6) begin
      @(negedge clk);
      check("bp_D_hold", D, 12'hC00);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid_hold", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    send(1'b1, 11'h123, 1'b0, acc);
    @(negedge clk);
    for (int n = 0; n < 50 && !in_ready; n++) @(negedge clk);
    check("bp_back_idle", in_ready, 1'b1);

    // Reset on the 5th SHIFT edge discards the conversion.
    send(1'b0, 11'h155, 1'b0, acc);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_back());
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_D", D, 12'h000);
    check("midrst_in_ready", in_ready, 1'b1);
    run_word(1'b1, 11'h00A);

    // Streaming: in_valid and out_ready tied high.
    prev_acc = 0;
    for (int i = 0; i < 4; i++) begin
      send(1'($urandom_range(0, 1)), W'($urandom_range(0, 2047)), 1'b1, acc);
      if (i > 0) check("accept_spacing", acc - prev_acc, 13);
      prev_acc = acc;
    end
    in_valid = 1'b0;
    for (int n = 0; n < 60 && sb.size() > 0; n++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
